// File: rtl/key_pkg.sv
// Shared definitions for the front-panel key scheduler: FSM encoding and default timing.
package key_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_VALID = 1'b1
    } key_state_t;

    localparam int KEY_TICK_DIV   = 500000;
    localparam int KEY_STABLE_CNT = 4;

endpackage

// File: rtl/key_debounce_lane.sv
// One key lane: 2-flop synchronizer, tick-sampled history, debounced level and press pulse.
module key_debounce_lane #(
    parameter int STABLE_CNT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic key,
    output logic level,
    output logic press
);

    logic                  sync1;
    logic                  sync2;
    logic                  level_prev;
    logic [STABLE_CNT-1:0] hist;
    logic [STABLE_CNT-1:0] hist_next;

    assign hist_next = {hist[STABLE_CNT-2:0], sync2};

    // NOTE: the synchronizer and history are cleared by reset as well, so a key held
    // through reset must collect a full run of fresh samples before level rises.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            hist       <= '0;
            level      <= 1'b0;
            level_prev <= 1'b0;
        end else begin
            sync1      <= key;
            sync2      <= sync1;
            level_prev <= level;
            if (tick) begin
                hist <= hist_next;
                if (&hist_next) begin
                    level <= 1'b1;
                end else if (~|hist_next) begin
                    level <= 1'b0;
                end
            end
        end
    end

    // Rising edge of the debounced level only; releases are not events.
    assign press = level & ~level_prev;

endmodule

// File: rtl/key_cmd_scheduler.sv
// Debounces N keys, queues one press per key and issues them by fixed priority on a
// valid/ready command channel; also keeps a per-key toggle and a sticky coalesce flag.
module key_cmd_scheduler
    import key_pkg::*;
#(
    parameter int N_KEYS     = 4,
    parameter int TICK_DIV   = KEY_TICK_DIV,
    parameter int STABLE_CNT = KEY_STABLE_CNT,
    parameter int IDW        = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key,
    input  logic              cmd_ready,
    output logic              cmd_valid,
    output logic [IDW-1:0]    cmd_id,
    output logic [N_KEYS-1:0] level,
    output logic [N_KEYS-1:0] tog,
    output logic [N_KEYS-1:0] drop
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0]     tick_cnt;
    logic              tick;
    logic [N_KEYS-1:0] press;
    logic [N_KEYS-1:0] pend;
    logic [N_KEYS-1:0] clr;
    logic [IDW-1:0]    grant_id;
    logic              accept;
    key_state_t        state;

    assign tick = (tick_cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    for (genvar k = 0; k < N_KEYS; k++) begin : g_lane
        key_debounce_lane #(
            .STABLE_CNT(STABLE_CNT)
        ) u_lane (
            .clk  (clk),
            .rst_n(rst_n),
            .tick (tick),
            .key  (key[k]),
            .level(level[k]),
            .press(press[k])
        );
    end

    // NOTE: every always_comb output gets a default before the loop, so no latch is inferred.
    always_comb begin
        grant_id = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (pend[i]) begin
                grant_id = IDW'(i);
            end
        end
    end

    assign accept = (state == S_VALID) && cmd_ready;

    always_comb begin
        clr = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            clr[i] = accept && (cmd_id == IDW'(i));
        end
    end

    // A press landing on the same cycle as its own clear re-queues rather than coalescing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend <= '0;
            drop <= '0;
            tog  <= '0;
        end else begin
            pend <= (pend & ~clr) | press;
            drop <= drop | (press & pend & ~clr);
            tog  <= tog ^ clr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cmd_valid <= 1'b0;
            cmd_id    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|pend) begin
                        cmd_id    <= grant_id;
                        cmd_valid <= 1'b1;
                        state     <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    cmd_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_cmd_scheduler.sv
// Self-checking bench: directed scenarios plus random key/ready/reset traffic against a
// run-length debounce model and a pending-set command model.
module tb_key_cmd_scheduler;

    localparam int N  = 4;
    localparam int TD = 4;
    localparam int SC = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] key;
    logic         cmd_ready;
    logic         cmd_valid;
    logic [1:0]   cmd_id;
    logic [N-1:0] level;
    logic [N-1:0] tog;
    logic [N-1:0] drop;

    int n_cmp = 0;
    int n_err = 0;

    key_cmd_scheduler #(
        .N_KEYS    (N),
        .TICK_DIV  (TD),
        .STABLE_CNT(SC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key      (key),
        .cmd_ready(cmd_ready),
        .cmd_valid(cmd_valid),
        .cmd_id   (cmd_id),
        .level    (level),
        .tog      (tog),
        .drop     (drop)
    );

    always #5 clk = ~clk;

    // Reference model state, as seen during the current cycle.
    int           m_phase;
    logic [N-1:0] m_d1, m_d2;
    int           m_run_val [N];
    int           m_run_len [N];
    logic [N-1:0] m_lvl, m_lvl_prev, m_pend, m_tog, m_drop;
    bit           m_offer;
    int           m_oid;
    int           acc_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [N-1:0] m);
        for (int i = 0; i < N; i++) if (m[i]) return i;
        return 0;
    endfunction

    // Advance the model across one rising edge using the inputs held during that cycle.
    task automatic model_edge();
        logic [N-1:0] press, clr, nl;
        bit           tick, acc;
        if (!rst_n) begin
            m_phase = 0; m_d1 = '0; m_d2 = '0;
            m_lvl = '0; m_lvl_prev = '0; m_pend = '0; m_tog = '0; m_drop = '0;
            m_offer = 0; m_oid = 0;
            for (int k = 0; k < N; k++) begin m_run_val[k] = 0; m_run_len[k] = SC; end
            return;
        end
        tick    = (m_phase == TD - 1);
        m_phase = (m_phase + 1) % TD;
        press   = m_lvl & ~m_lvl_prev;
        acc     = m_offer && cmd_ready;
        clr     = '0;
        if (acc) clr[m_oid] = 1'b1;
        nl = m_lvl;
        if (tick) begin
            for (int k = 0; k < N; k++) begin
                if (int'(m_d2[k]) == m_run_val[k]) begin
                    if (m_run_len[k] < 1000) m_run_len[k]++;
                end else begin
                    m_run_val[k] = int'(m_d2[k]);
                    m_run_len[k] = 1;
                end
                if (m_run_len[k] >= SC) nl[k] = m_d2[k];
            end
        end
        m_lvl_prev = m_lvl;
        m_lvl      = nl;
        m_drop     = m_drop | (press & m_pend & ~clr);
        if (m_offer) begin
            if (acc) m_offer = 0;
        end else if (m_pend != '0) begin
            m_oid   = lowest(m_pend);
            m_offer = 1;
        end
        m_pend = (m_pend & ~clr) | press;
        m_tog  = m_tog ^ clr;
        m_d2   = m_d1;
        m_d1   = key;
    endtask

    task automatic cycle();
        if (rst_n === 1'b1 && cmd_valid === 1'b1 && cmd_ready === 1'b1) acc_q.push_back(int'(cmd_id));
        @(posedge clk);
        model_edge();
        #1;
        check("level", 32'(level), 32'(m_lvl));
        check("cmd_valid", 32'(cmd_valid), 32'(m_offer));
        if (m_offer) check("cmd_id", 32'(cmd_id), m_oid);
        check("tog", 32'(tog), 32'(m_tog));
        check("drop", 32'(drop), 32'(m_drop));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_valid(input int max, output int n);
        n = 0;
        while (cmd_valid !== 1'b1 && n < max) begin
            cycle();
            n++;
        end
        check("wait_valid_timeout", 32'(cmd_valid), 32'd1);
    endtask

    task automatic check_seq(input string tag, input int n, input int a, input int b);
        check({tag, "_count"}, acc_q.size(), n);
        if (n > 0 && acc_q.size() > 0) check({tag, "_id0"}, acc_q[0], a);
        if (n > 1 && acc_q.size() > 1) check({tag, "_id1"}, acc_q[1], b);
        acc_q.delete();
    endtask

    initial begin
        int n;
        int hold;
        rst_n = 1'b0; key = '0; cmd_ready = 1'b0;
        run(3);
        check("rst_valid", 32'(cmd_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        rst_n = 1'b1;

        // Reset in the middle of an offered command.
        key = 4'b0001;
        wait_valid(60, n);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check("mid_rst_valid", 32'(cmd_valid), 32'd0);
        check("mid_rst_tog", 32'(tog), 32'd0);
        wait_valid(60, n);
        check("mid_rst_fresh_ticks", 32'(n >= 3 * TD), 32'd1);
        cmd_ready = 1'b1; key = '0;
        run(40);
        acc_q.delete();

        // Clean press of key 2.
        key = 4'b0100;
        run(20 * TD);
        check("clean_level", 32'(level[2]), 32'd1);
        key = '0;
        run(40);
        check_seq("clean", 1, 2, 0);

        // Bounce on key 1: runs of 5 clk never span three ticks.
        for (int i = 0; i < 12; i++) begin
            key[1] = ~key[1];
            run(5);
        end
        key = '0;
        run(30);
        check_seq("bounce", 0, 0, 0);

        // Simultaneous presses on keys 1 and 3.
        key = 4'b1010;
        run(80);
        key = '0;
        run(40);
        check_seq("simul", 2, 1, 3);

        // Backpressure: id stays 0 while key 3 arrives later.
        cmd_ready = 1'b0;
        key = 4'b0001;
        run(40);
        key = 4'b1001;
        run(40);
        check("bp_id", 32'(cmd_id), 32'd0);
        cmd_ready = 1'b1;
        run(20);
        key = '0;
        run(40);
        check_seq("backpressure", 2, 0, 3);

        // Coalesce: second press of key 0 while its command is still pending.
        cmd_ready = 1'b0;
        key = 4'b0001; run(30);
        key = '0;      run(30);
        key = 4'b0001; run(30);
        key = '0;      run(30);
        check("coalesce_drop", 32'(drop[0]), 32'd1);
        cmd_ready = 1'b1;
        run(20);
        check_seq("coalesce", 1, 0, 0);

        // Random traffic with occasional resets.
        hold = 0;
        for (int i = 0; i < 2500; i++) begin
            if (hold == 0) begin
                key  = 4'($urandom);
                hold = $urandom_range(1, 24);
            end
            hold--;
            cmd_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 599) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/key_cmd_scheduler.md
Name: key_cmd_scheduler

Overview:
- Front-panel input controller for the single-cycle CPU board design.
- Debounces N push-buttons using one shared sample-tick divider and detects press edges.
- Queues one pending press per key and arbitrates them, fixed priority, onto a single valid/ready command channel toward the CPU control logic (step clock, reset request, display page, …).
- Also keeps a per-key toggle level for mode switches.

Parameters:
- N_KEYS, 4, number of raw key inputs (≥1).
- TICK_DIV, 500000, clk cycles per debounce sample tick (≥2).
- STABLE_CNT, 4, consecutive equal samples needed to change a debounced level (≥2).
- IDW, $clog2(N_KEYS) (min 1), width of cmd_id.

Ports:
- clk, in, 1, system clock; all logic on posedge.
- rst_n, in, 1, reset; synchronous, active-low.
- key, in, N_KEYS, raw asynchronous buttons, active-high.
- cmd_ready, in, 1, consumer accepts cmd_id this cycle.
- cmd_valid, out, 1, command pending on cmd_id.
- cmd_id, out, IDW, index of the granted key.
- level, out, N_KEYS, debounced key levels.
- tog, out, N_KEYS, per-key toggle; flips on each accepted command for that key.
- drop, out, N_KEYS, sticky flag: a press was coalesced while that key's command was still pending.

Behaviour:
- Reset (rst_n=0 at posedge): tick counter=0, sync flops=0, sample history=0, level=0, pend=0, tog=0, drop=0, cmd_valid=0, cmd_id=0, FSM=S_IDLE. Reset wins over every other event, including mid-handshake; any pending command is discarded.
- Tick:
  - Counter counts 0..TICK_DIV-1 and wraps.
  - tick is a 1-cycle pulse in the cycle the counter equals TICK_DIV-1.
  - One tick is shared by all lanes.
- Per-key lane:
  - key[k] passes through a 2-flop synchronizer.
  - On tick, the synchronized value shifts into hist[k] (STABLE_CNT bits).
  - If hist is all ones after the shift, level[k]←1. If all zeros, level[k]←0. Otherwise hold.
  - press[k] = level[k] rose (registered previous vs current): a 1-cycle pulse, one cycle after level[k] changes.
  - Release produces no event.
- Pending set/clear:
  - press[k] sets pend[k].
  - Handshake completion for id k clears pend[k].
  - press[k] in the same cycle as the clear of k: pend[k] stays 1 (new press queued, not lost).
  - press[k] while pend[k]=1 and no clear: press coalesced, drop[k]←1. drop clears only on reset.
- FSM:
  - S_IDLE: if pend≠0, cmd_id←lowest index with pend=1, cmd_valid←1, go to S_VALID. Else stay.
  - S_VALID: cmd_valid=1, cmd_id stable. When cmd_ready=1: pend[cmd_id]←0, tog[cmd_id] flips, cmd_valid←0 next cycle, go to S_IDLE.
  - cmd_id must not change while cmd_valid=1, even if a higher-priority key becomes pending.
  - Minimum 2 cycles between successive commands (one idle cycle re-arbitrates).
- Latency: press[k] pulse → pend[k]=1 next cycle → cmd_valid=1 the cycle after (from S_IDLE).
- Debounce latency: STABLE_CNT ticks after the key is stable, plus up to TICK_DIV+3 clk.
- cmd_ready while cmd_valid=0 is ignored.
- Bounce shorter than STABLE_CNT consecutive ticks never changes level.
- Widths: tick counter is $clog2(TICK_DIV) bits and never exceeds TICK_DIV-1. No other arithmetic.

Decomposition:
- Shared package key_pkg holds:
  - state encoding: S_IDLE=1'b0, S_VALID=1'b1;
  - default constants KEY_TICK_DIV=500000 and KEY_STABLE_CNT=4.
- Natural sub-module: key_debounce_lane (synchronizer, history shift, level, press pulse), instantiated N_KEYS times via generate. Tick divider, pend/drop/tog registers and FSM stay in the top.

Test Plan (N_KEYS=4, TICK_DIV=4, STABLE_CNT=3):
- Reset mid-operation: key=4'b0001 held long enough for cmd_valid=1, then rst_n=0 for 1 cycle → the cycle after reset, cmd_valid=0, level=0, tog=0, drop=0, pend empty. With key[0] still held, a new command appears only after ≥3 fresh ticks.
- Clean press: key[2] 0→1 held 20 ticks, cmd_ready=1 → level[2]=1 after 3 ticks, exactly one cmd_valid cycle with cmd_id=2, tog[2]=1, drop=0.
- Bounce: key[1] toggles every 5 clk for 60 clk, then 0 → level[1] stays 0, no cmd_valid.
- Simultaneous presses: key=4'b1010 same cycle, cmd_ready=1 → commands in order id=1 then id=3, separated by ≥1 cmd_valid=0 cycle. tog=4'b1010.
- Backpressure: cmd_ready=0 while key[0] pressed, then key[3] pressed → cmd_id stays 0 throughout. Raising cmd_ready yields id 0 then id 3.
- Coalesce: cmd_ready=0; press key[0], release (level 0), press again → drop[0]=1. After cmd_ready=1, exactly one id=0 command, tog[0]=1.
